// File: rtl/muxn_stream_reg_pkg.sv
// rtl/muxn_stream_reg_pkg.sv - shared mode type and index helper for the stream mux
package muxn_stream_reg_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mux_mode_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/muxn_stream_reg_rr_arbiter.sv
// rtl/muxn_stream_reg_rr_arbiter.sv - combinational round-robin arbiter, first requester at or after ptr
module rr_arbiter #(
   parameter int N = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] idx
);

   int               pos;
   logic [SELW-1:0]  pos_w;
   logic             found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      pos_w = '0;
      for (int k = 0; k < N; k++) begin
         // Wrap the scan position without a modulo so non-power-of-2 N stays cheap
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         pos_w = SELW'(pos);
         if (!found && req[pos_w]) begin
            found        = 1'b1;
            grant[pos_w] = 1'b1;
            idx          = pos_w;
         end
      end
   end

endmodule

// File: rtl/muxn_stream_reg.sv
// rtl/muxn_stream_reg.sv - N-input registered stream mux with explicit-select and round-robin modes
module muxn_stream_reg
   import muxn_stream_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  mux_mode_t          mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_ch,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [SELW-1:0]  ptr;
   logic [N-1:0]     rr_grant;
   logic [SELW-1:0]  rr_idx;
   logic [N-1:0]     sel_grant;
   logic [N-1:0]     grant;
   logic [SELW-1:0]  gidx;
   logic [WIDTH-1:0] gdata;
   logic             has_grant;
   logic             load;

   rr_arbiter #(.N(N)) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   always_comb begin
      sel_grant = '0;
      gdata     = '0;
      // An out-of-range sel matches no channel index, so it never grants
      for (int i = 0; i < N; i++) begin
         sel_grant[i] = in_valid[i] && (sel == SELW'(i));
      end
      grant     = (mode == MODE_RR) ? rr_grant : sel_grant;
      gidx      = (mode == MODE_RR) ? rr_idx : sel;
      has_grant = |grant;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) gdata = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign load     = ~out_valid | out_ready;
   assign in_ready = (load && !rst) ? grant : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (has_grant) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            out_ch    <= gidx;
            if (mode == MODE_RR) ptr <= SELW'(wrap_inc(int'(gidx), N));
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_muxn_stream_reg.sv
// tb/tb_muxn_stream_reg.sv - lockstep bench for N=4 and N=3 instances against a behavioural model
module tb_muxn_stream_reg;
   import muxn_stream_reg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   mux_mode_t   mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic        out_ready;

   logic [3:0]  a_ready;
   logic [7:0]  a_data;
   logic [1:0]  a_ch;
   logic        a_valid;
   logic [2:0]  b_ready;
   logic [7:0]  b_data;
   logic [1:0]  b_ch;
   logic        b_valid;

   int tests = 0;
   int fails = 0;

   int mv[2];
   int md[2];
   int mc[2];
   int mp[2];
   int nch[2] = '{4, 3};

   always #5 clk = ~clk;

   muxn_stream_reg #(.WIDTH(8), .N(4)) dut_a (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
      .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid), .out_ready(out_ready)
   );

   muxn_stream_reg #(.WIDTH(8), .N(3)) dut_b (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(b_ready),
      .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid), .out_ready(out_ready)
   );

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Which channel the spec's rules pick this cycle, -1 for none
   function automatic int pick(input int id);
      int n;
      logic [3:0] v;
      n = nch[id];
      v = in_valid;
      if (id == 1) v[3] = 1'b0;
      if (rst) return -1;
      if (mode == MODE_SEL) return (int'(sel) < n && v[sel]) ? int'(sel) : -1;
      for (int k = 0; k < n; k++) begin
         if (v[(mp[id] + k) % n]) return (mp[id] + k) % n;
      end
      return -1;
   endfunction

   task automatic step();
      int g[2];
      int ld[2];
      int dat[2];
      #1;
      for (int id = 0; id < 2; id++) begin
         ld[id]  = (mv[id] == 0 || out_ready) ? 1 : 0;
         g[id]   = ld[id] ? pick(id) : -1;
         dat[id] = (g[id] >= 0) ? int'(in_data[g[id]*8 +: 8]) : 0;
      end
      check("a_in_ready", int'(a_ready), (g[0] >= 0) ? (1 << g[0]) : 0);
      check("b_in_ready", int'(b_ready), (g[1] >= 0) ? (1 << g[1]) : 0);
      @(posedge clk);
      for (int id = 0; id < 2; id++) begin
         if (rst) begin
            mv[id] = 0; md[id] = 0; mc[id] = 0; mp[id] = 0;
         end else if (ld[id] != 0) begin
            if (g[id] >= 0) begin
               mv[id] = 1; md[id] = dat[id]; mc[id] = g[id];
               if (mode == MODE_RR) mp[id] = (g[id] + 1) % nch[id];
            end else begin
               mv[id] = 0;
            end
         end
      end
      #1;
      check("a_out_valid", int'(a_valid), mv[0]);
      check("a_out_data",  int'(a_data),  md[0]);
      check("a_out_ch",    int'(a_ch),    mc[0]);
      check("b_out_valid", int'(b_valid), mv[1]);
      check("b_out_data",  int'(b_data),  md[1]);
      check("b_out_ch",    int'(b_ch),    mc[1]);
   endtask

   initial begin
      logic [7:0] held;
      for (int id = 0; id < 2; id++) begin
         mv[id] = 0; md[id] = 0; mc[id] = 0; mp[id] = 0;
      end
      rst = 1'b1; mode = MODE_RR; sel = 2'd0;
      in_data = 32'h4433_2211; in_valid = 4'hF; out_ready = 1'b1;

      step();
      step();
      check("reset_valid", int'(a_valid), 0);
      check("reset_data",  int'(a_data),  0);

      rst = 1'b0;
      step();
      check("first_rr_ch", int'(a_ch), 0);

      mode = MODE_SEL; sel = 2'd2; in_data = 32'h11A5_3344; in_valid = 4'b0100;
      step();
      check("sel2_data", int'(a_data), 8'hA5);
      check("sel2_ch",   int'(a_ch),   2);

      sel = 2'd3; in_valid = 4'b0111;
      step();
      check("sel3_a_none", int'(a_valid), 0);
      check("sel3_b_none", int'(b_valid), 0);

      mode = MODE_RR; in_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         in_data = $urandom;
         step();
         check("rr_all_a", int'(a_ch), (i + 1) % 4);
         check("rr_all_b", int'(b_ch), (i + 1) % 3);
      end

      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rr_1010", int'(a_ch), (i % 2 == 0) ? 1 : 3);
      end

      in_valid = 4'hF; in_data = $urandom;
      step();
      held = a_data;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         step();
         check("stall_hold", int'(a_data), int'(held));
      end
      out_ready = 1'b1;
      step();

      rst = 1'b1;
      step();
      rst = 1'b0; mode = MODE_RR; in_valid = 4'b0010;
      step();
      mode = MODE_SEL; sel = 2'd0; in_valid = 4'hF;
      step();
      step();
      mode = MODE_RR;
      step();
      check("switch_back_ch2", int'(a_ch), 2);

      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         mode      = mux_mode_t'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_data   = $urandom;
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
